// File: rtl/rx_unit_deserializer_if.sv
// Bus bundle between the Rx deserializer and its environment (Tx serial line, APB decoder).
// Master drives the serial line and read strobe; slave is the deserializer itself.
interface rx_unit_deserializer_if;
    logic       serial_in;
    logic       parity_sel;
    logic       read;
    logic       Rx_ready;
    logic [7:0] data_out;
    logic       parity_err;
    logic       rd_err;
    logic       frame_err;
    logic       overrun;
    logic       PREADY_R;
    logic       RxFE;
    logic       RxFF;

    modport master (
        output serial_in, parity_sel, read,
        input  Rx_ready, data_out, parity_err, rd_err, frame_err, overrun,
               PREADY_R, RxFE, RxFF
    );

    modport slave (
        input  serial_in, parity_sel, read,
        output Rx_ready, data_out, parity_err, rd_err, frame_err, overrun,
               PREADY_R, RxFE, RxFF
    );
endinterface

// File: rtl/rx_unit_deserializer.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop; one bit per baud_clk.
// Received bytes plus parity-error flag are queued in a FIFO and popped by APB reads.
module rx_unit_deserializer #(
    parameter int FIFO_WIDTH_R = 9,
    parameter int FIFO_DEPTH_R = 16
) (
    input  logic                    baud_clk,
    input  logic                    rst,
    rx_unit_deserializer_if.slave   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH_R);
    localparam int CNT_W = $clog2(FIFO_DEPTH_R + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH_R);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_shreg;
    logic [7:0]             w_shreg_nxt;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             w_bit_cnt_nxt;
    logic                   r_perr;
    logic                   w_perr_nxt;
    logic                   w_stop_ok;
    logic                   w_stop_bad;

    logic [FIFO_WIDTH_R-1:0] r_mem [FIFO_DEPTH_R];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [FIFO_WIDTH_R-1:0] w_wdata;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_overrun;

    logic                   r_rx_ready;
    logic [7:0]             r_data_out;
    logic                   r_parity_err;
    logic                   r_rd_err;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_pready;

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_perr    <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_perr_nxt    = r_perr;
        w_stop_ok     = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.serial_in) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                w_shreg_nxt   = {bus.serial_in, r_shreg[7:1]};
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                // Nonzero whenever data+parity ones count mismatches the selected sense.
                w_perr_nxt  = bus.serial_in ^ (^r_shreg) ^ bus.parity_sel;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bus.serial_in) begin
                    w_stop_ok = 1'b1;
                end else begin
                    w_stop_bad = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = bus.read && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign w_push    = w_stop_ok && (!w_full || w_pop);
    assign w_overrun = w_stop_ok && w_full && !w_pop;
    assign w_wdata   = FIFO_WIDTH_R'({r_perr, r_shreg});

    always_ff @(posedge baud_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_rx_ready   <= 1'b1;
            r_data_out   <= '0;
            r_parity_err <= 1'b0;
            r_rd_err     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_pready     <= 1'b0;
        end else begin
            r_rx_ready  <= !w_full;
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_overrun;
            r_pready    <= bus.read;
            r_rd_err    <= bus.read && w_empty;
            if (w_pop) begin
                r_data_out   <= r_mem[r_rd_ptr][7:0];
                r_parity_err <= r_mem[r_rd_ptr][8];
            end else if (bus.read) begin
                r_data_out   <= '0;
                r_parity_err <= 1'b0;
            end
        end
    end

    assign bus.Rx_ready   = r_rx_ready;
    assign bus.data_out   = r_data_out;
    assign bus.parity_err = r_parity_err;
    assign bus.rd_err     = r_rd_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.PREADY_R   = r_pready;
    assign bus.RxFE       = w_empty;
    assign bus.RxFF       = w_full;

endmodule

// File: tb/tb_rx_unit_deserializer.sv
// Bench for rx_unit_deserializer: directed frames plus randomized frames/reads,
// checked against a queue-based model of the receive FIFO.
module tb_rx_unit_deserializer;

    localparam int DEPTH = 16;

    logic baud_clk = 1'b0;
    logic rst;

    always #5 baud_clk = ~baud_clk;

    rx_unit_deserializer_if bus ();

    rx_unit_deserializer #(
        .FIFO_WIDTH_R (9),
        .FIFO_DEPTH_R (DEPTH)
    ) dut (
        .baud_clk (baud_clk),
        .rst      (rst),
        .bus      (bus)
    );

    logic [8:0] q[$];
    logic [7:0] last_data;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // Called one sample after the edge that consumed a read strobe.
    task automatic expect_read(input string tag);
        logic [8:0] w;
        check_eq({tag, "_pready"}, bus.PREADY_R, 1);
        if (q.size() > 0) begin
            w = q.pop_front();
            last_data = w[7:0];
            check_eq({tag, "_data"}, bus.data_out, w[7:0]);
            check_eq({tag, "_perr"}, bus.parity_err, w[8]);
            check_eq({tag, "_rderr"}, bus.rd_err, 0);
        end else begin
            last_data = 8'h00;
            check_eq({tag, "_data_empty"}, bus.data_out, 0);
            check_eq({tag, "_perr_empty"}, bus.parity_err, 0);
            check_eq({tag, "_rderr"}, bus.rd_err, 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit psel, input bit bad_par,
                              input bit bad_stop, input bit rd_at_stop);
        bit p;
        bit exp_fe;
        bit exp_ov;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        bus.parity_sel = psel;
        p = (^d) ^ psel ^ bad_par;
        bus.serial_in = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.serial_in = d[i];
            tick();
        end
        bus.serial_in = p;
        tick();
        bus.serial_in = !bad_stop;
        bus.read = rd_at_stop;
        tick();
        bus.read = 1'b0;
        bus.serial_in = 1'b1;
        if (rd_at_stop) expect_read("stop_read");
        if (bad_stop) exp_fe = 1'b1;
        else if (q.size() == DEPTH) exp_ov = 1'b1;
        else q.push_back({bad_par, d});
        check_eq("frame_err", bus.frame_err, exp_fe);
        check_eq("overrun", bus.overrun, exp_ov);
        check_eq("RxFE", bus.RxFE, q.size() == 0);
        check_eq("RxFF", bus.RxFF, q.size() == DEPTH);
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        tick();
        check_eq("pulse_fe_clear", bus.frame_err, 0);
        check_eq("pulse_ov_clear", bus.overrun, 0);
        check_eq("Rx_ready", bus.Rx_ready, q.size() != DEPTH);
        for (int i = 1; i < n; i++) tick();
    endtask

    task automatic read_burst(input int n);
        bus.read = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            expect_read("read");
        end
        bus.read = 1'b0;
        tick();
        check_eq("pready_drop", bus.PREADY_R, 0);
        check_eq("rderr_drop", bus.rd_err, 0);
        check_eq("data_hold", bus.data_out, last_data);
        check_eq("RxFE_after_read", bus.RxFE, q.size() == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.serial_in = 1'b1;
        bus.parity_sel = 1'b0;
        bus.read = 1'b0;
        last_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_data", bus.data_out, 0);
        check_eq("rst_perr", bus.parity_err, 0);
        check_eq("rst_pready", bus.PREADY_R, 0);
        check_eq("rst_rderr", bus.rd_err, 0);
        check_eq("rst_fe", bus.frame_err, 0);
        check_eq("rst_ov", bus.overrun, 0);
        check_eq("rst_RxFE", bus.RxFE, 1);
        check_eq("rst_RxFF", bus.RxFF, 0);
        check_eq("rst_Rx_ready", bus.Rx_ready, 1);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        read_burst(1);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        read_burst(1);

        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_eq("fe_empty", bus.RxFE, 1);
        send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        read_burst(1);

        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check_eq("full_RxFF", bus.RxFF, 1);
        check_eq("full_ready", bus.Rx_ready, 0);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        read_burst(DEPTH);
        check_eq("drained_RxFE", bus.RxFE, 1);

        read_burst(1);

        bus.parity_sel = 1'b0;
        bus.serial_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = 1'(i & 1);
            tick();
        end
        rst = 1'b1;
        bus.serial_in = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        last_data = 8'h00;
        check_eq("midrst_RxFE", bus.RxFE, 1);
        check_eq("midrst_data", bus.data_out, 0);
        idle(12);
        check_eq("midrst_nopush", bus.RxFE, 1);

        for (int it = 0; it < 80; it++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end else begin
                idle(1);
                read_burst($urandom_range(1, 4));
            end
        end
        idle(1);
        read_burst(DEPTH + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
